// File: rtl/tcs_scan_sequencer.sv
// Colour-sensor scan sequencer: steps the TCS3200 filters red/blue/green/clear,
// counts frequency edges per gated window and publishes one coherent frame.
module tcs_scan_sequencer #(
  parameter int         SETTLE_CYCLES = 1_000_000,
  parameter int         GATE_CYCLES   = 12_500_000,
  parameter int         CNT_W         = 25,
  parameter logic [1:0] SCALE         = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             freq_in,
  output logic             select0,
  output logic             select1,
  output logic             select2,
  output logic             select3,
  output logic             oe_n,
  output logic             busy,
  output logic             frame_valid,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] clear,
  output logic             overflow
);

  localparam int MAXC  = (GATE_CYCLES > SETTLE_CYCLES) ?
                         GATE_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W = $clog2(MAXC + 1);
  localparam logic [CYC_W-1:0] SET_LAST  = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_STORE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       chan_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] sh_red_q;
  logic [CNT_W-1:0] sh_blue_q;
  logic [CNT_W-1:0] sh_green_q;
  logic [1:0]       sel01_q;
  logic [1:0]       sel23_q;
  logic             oe_n_q;
  logic             busy_q;
  logic             fv_q;
  logic [CNT_W-1:0] red_q;
  logic [CNT_W-1:0] blue_q;
  logic [CNT_W-1:0] green_q;
  logic [CNT_W-1:0] clear_q;
  logic             ovo_q;
  logic             rise;

  // {S2,S3} per channel index: red, blue, green, clear
  function automatic logic [1:0] filt(input logic [1:0] ch);
    logic [1:0] f;
    case (ch)
      2'd0:    f = 2'b00;
      2'd1:    f = 2'b01;
      2'd2:    f = 2'b11;
      default: f = 2'b10;
    endcase
    return f;
  endfunction

  assign rise = sync_q[1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chan_q     <= 2'd0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sync_q     <= 2'b00;
      prev_q     <= 1'b0;
      sh_red_q   <= '0;
      sh_blue_q  <= '0;
      sh_green_q <= '0;
      sel01_q    <= 2'b00;
      sel23_q    <= 2'b00;
      oe_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      red_q      <= '0;
      blue_q     <= '0;
      green_q    <= '0;
      clear_q    <= '0;
      ovo_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], freq_in};
      prev_q <= sync_q[1];
      fv_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start || continuous) begin
            state_q <= S_SETTLE;
            chan_q  <= 2'd0;
            cyc_q   <= '0;
            sel01_q <= SCALE;
            sel23_q <= filt(2'd0);
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cyc_q == SET_LAST) begin
            cyc_q   <= '0;
            state_q <= S_GATE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_GATE: begin
          if (rise) begin
            if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
            else                  cnt_q <= cnt_q + 1'b1;
          end
          if (cyc_q == GATE_LAST) begin
            cyc_q   <= '0;
            state_q <= S_STORE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_STORE: begin
          cnt_q  <= '0;
          chan_q <= chan_q + 2'd1;
          case (chan_q)
            2'd0:    sh_red_q   <= cnt_q;
            2'd1:    sh_blue_q  <= cnt_q;
            2'd2:    sh_green_q <= cnt_q;
            default: ;
          endcase
          // clear goes straight out so the whole frame lands together
          if (chan_q == 2'd3) begin
            state_q <= S_DONE;
            red_q   <= sh_red_q;
            blue_q  <= sh_blue_q;
            green_q <= sh_green_q;
            clear_q <= cnt_q;
            ovo_q   <= ovf_q;
            ovf_q   <= 1'b0;
            fv_q    <= 1'b1;
          end else begin
            state_q <= S_SETTLE;
            sel23_q <= filt(chan_q + 2'd1);
          end
        end
        S_DONE: begin
          if (continuous) begin
            state_q <= S_SETTLE;
            chan_q  <= 2'd0;
            sel23_q <= filt(2'd0);
          end else begin
            state_q <= S_IDLE;
            sel01_q <= 2'b00;
            sel23_q <= 2'b00;
            oe_n_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign select0     = sel01_q[1];
  assign select1     = sel01_q[0];
  assign select2     = sel23_q[1];
  assign select3     = sel23_q[0];
  assign oe_n        = oe_n_q;
  assign busy        = busy_q;
  assign frame_valid = fv_q;
  assign red         = red_q;
  assign blue        = blue_q;
  assign green       = green_q;
  assign clear       = clear_q;
  assign overflow    = ovo_q;

endmodule

// File: tb/tb_tcs_scan_sequencer.sv
// Scoreboard bench for tcs_scan_sequencer: frames expected at start are
// queued and compared when frame_valid fires.
module tb_tcs_scan_sequencer;

  localparam int ST = 4;
  localparam int GT = 100;
  localparam int FR = 4 * (ST + GT + 1) + 1;

  logic clk = 1'b0;
  logic rst, start, start_s, continuous, freq_in;
  logic s0, s1, s2, s3, oe_n, busy, fv;
  logic [24:0] red, blue, green, clr;
  logic ovf;
  logic t0_s0, t0_s1, t0_s2, t0_s3, oe_n_s, busy_s, fv_s;
  logic [3:0] red_s, blue_s, green_s, clr_s;
  logic ovf_s;

  typedef struct {
    int          t;
    logic [24:0] r, b, g, c;
    logic        o;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  logic [1:0] seq[$];
  logic [1:0] exp_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int mode = 3;
  int per = 10;
  int t0 = 0;
  int s01_bad = 0;
  bit fmon = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcs_scan_sequencer #(
    .SETTLE_CYCLES(ST), .GATE_CYCLES(GT),
    .CNT_W(25), .SCALE(2'b10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .continuous(continuous), .freq_in(freq_in),
    .select0(s0), .select1(s1), .select2(s2), .select3(s3),
    .oe_n(oe_n), .busy(busy), .frame_valid(fv),
    .red(red), .blue(blue), .green(green), .clear(clr),
    .overflow(ovf)
  );

  tcs_scan_sequencer #(
    .SETTLE_CYCLES(ST), .GATE_CYCLES(GT),
    .CNT_W(4), .SCALE(2'b10)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .continuous(1'b0), .freq_in(freq_in),
    .select0(t0_s0), .select1(t0_s1),
    .select2(t0_s2), .select3(t0_s3),
    .oe_n(oe_n_s), .busy(busy_s), .frame_valid(fv_s),
    .red(red_s), .blue(blue_s), .green(green_s), .clear(clr_s),
    .overflow(ovf_s)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sensor model, driven away from the sampling edge
  initial begin
    int p;
    int pp;
    freq_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0: freq_in = (cyc % per) < (per / 2);
        1: begin
          case ({s2, s3})
            2'b00:   pp = 5;
            2'b01:   pp = 10;
            2'b11:   pp = 20;
            default: pp = 4;
          endcase
          freq_in = (cyc % pp) < (pp / 2);
        end
        2: begin
          if (cyc > t0) begin
            p = (cyc - t0 - 1) % (ST + GT + 1);
            freq_in = (p == ST + GT) || (p == 1);
          end else begin
            freq_in = 1'b0;
          end
        end
        default: freq_in = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (fv) begin
      if (q.size() == 0) check("fv_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("fv_time", cyc, e.t);
        check("red", red, e.r);
        check("blue", blue, e.b);
        check("green", green, e.g);
        check("clear", clr, e.c);
        check("overflow", ovf, e.o);
      end
    end
    if (fv_s) begin
      if (qs.size() == 0) check("fv_s_unexpected", 1, 0);
      else begin
        e = qs.pop_front();
        check("s_fv_time", cyc, e.t);
        check("s_red", red_s, e.r);
        check("s_blue", blue_s, e.b);
        check("s_green", green_s, e.g);
        check("s_clear", clr_s, e.c);
        check("s_overflow", ovf_s, e.o);
      end
    end
    if (fmon && busy) begin
      if ({s0, s1} != 2'b10) s01_bad++;
      if (seq.size() == 0 || seq[$] != {s2, s3})
        seq.push_back({s2, s3});
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input int t, input logic [24:0] v,
                      input logic o);
    q.push_back('{t: t, r: v, b: v, g: v, c: v, o: o});
  endtask

  task automatic idle_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_oe_n"}, oe_n, 1);
    check({tag, "_sel"}, {s0, s1, s2, s3}, 0);
    check({tag, "_fv"}, fv, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    idle_outs("rst");
    check("rst_counts", {red[7:0], blue[7:0], green[7:0], clr[7:0]}, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // single frame, period 10
    mode = 0;
    per = 10;
    repeat (3) @(negedge clk);
    check("busy_pre", busy, 0);
    pulse(t);
    push(t + FR, 25'd10, 1'b0);
    check("busy_rise", busy, 1);
    check("oe_n_scan", oe_n, 0);
    wait_until(t + FR + 1);
    idle_outs("post1");

    // per-filter sensor periods
    mode = 1;
    fmon = 1;
    repeat (3) @(negedge clk);
    pulse(t);
    q.push_back('{t: t + FR, r: 25'd20, b: 25'd10,
                  g: 25'd5, c: 25'd25, o: 1'b0});
    wait_until(t + FR + 1);
    fmon = 0;
    check("seq_len", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seq.size()) check("seq_s23", seq[i], exp_seq[i]);
    check("s01_scan", s01_bad, 0);

    // saturation on the 4-bit instance, then a clean frame
    mode = 0;
    per = 4;
    repeat (3) @(negedge clk);
    @(negedge clk);
    start_s = 1'b1;
    t = cyc;
    qs.push_back('{t: t + FR, r: 25'd15, b: 25'd15,
                   g: 25'd15, c: 25'd15, o: 1'b1});
    @(negedge clk);
    start_s = 1'b0;
    wait_until(t + FR + 2);
    per = 10;
    @(negedge clk);
    start_s = 1'b1;
    t = cyc;
    qs.push_back('{t: t + FR, r: 25'd10, b: 25'd10,
                   g: 25'd10, c: 25'd10, o: 1'b0});
    @(negedge clk);
    start_s = 1'b0;
    wait_until(t + FR + 1);
    check("s_busy_end", busy_s, 0);

    // continuous: three frames held, dropped during the fourth
    @(negedge clk);
    continuous = 1'b1;
    t = cyc;
    for (int i = 1; i <= 4; i++) push(t + i * FR, 25'd10, 1'b0);
    wait_until(t + 3 * FR + 200);
    continuous = 1'b0;
    wait_until(t + 4 * FR + 1);
    check("cont_busy_end", busy, 0);

    // start pulses while busy are ignored
    repeat (3) @(negedge clk);
    pulse(t);
    push(t + FR, 25'd10, 1'b0);
    wait_until(t + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + FR + 1);
    check("ign_busy_end", busy, 0);
    wait_until(t + FR + 30);
    check("ign_no_extra", busy, 0);

    // reset during blue GATE
    pulse(t);
    wait_until(t + 150);
    check("blue_s23", {s2, s3}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    idle_outs("midrst");
    check("midrst_counts", red | blue | green | clr, 0);
    check("midrst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (FR + 20) @(negedge clk);
    check("midrst_idle", busy, 0);

    // edges only around STORE/SETTLE are not counted
    mode = 3;
    repeat (5) @(negedge clk);
    pulse(t);
    t0 = t;
    mode = 2;
    push(t + FR, 25'd0, 1'b0);
    wait_until(t + FR + 1);
    mode = 3;
    repeat (5) @(negedge clk);

    check("q_drained", q.size(), 0);
    check("qs_drained", qs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
